// File: rtl/sseg_scan_n.sv
// N-digit multiplexed seven-segment controller with hex or sequential binary-to-BCD display.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan_n #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data,
  input  logic                  load,
  input  logic                  hex_dec,
  input  logic                  sign,
  input  logic [NUM_DIGITS-1:0] dp_sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  busy
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned MAG_W = DATA_W + BCD_W;
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegZero  = 7'h40;

  typedef enum logic {StIdle, StConv} state_e;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  state_e                         state_q, state_d;
  logic [DIV_W-1:0]               div_q, div_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BCD_W-1:0]               bcd_q, bcd_d;
  logic [DATA_W-1:0]              sh_q, sh_d;
  logic                           ovf_q, ovf_d;
  logic                           neg_q, neg_d;
  logic                           sgn_q, sgn_d;
  logic [NUM_DIGITS-1:0][6:0]     disp_seg_q, disp_seg_d;
  logic [NUM_DIGITS-1:0]          disp_blank_q, disp_blank_d;
  logic [NUM_DIGITS-1:0]          an_q;
  logic [6:0]                     seg_q;
  logic                           dp_q;

  logic                           neg_in;
  logic [DATA_W-1:0]              mag;
  logic [MAG_W-1:0]               mag_ext;
  int                             avail_in;
  logic                           hex_ovf;
  logic [BCD_W-1:0]               bcd_adj;
  logic [BCD_W-1:0]               bcd_step;
  logic                           carry;
  logic                           swap;
  logic [BCD_W-1:0]               src_nib;
  logic                           src_ovf;
  logic                           src_neg;
  logic                           src_sgn;
  logic [NUM_DIGITS-1:0][6:0]     new_seg;
  logic [NUM_DIGITS-1:0]          new_blank;

  // Refresh divider and digit index.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    neg_in   = sign & data[DATA_W-1];
    mag      = neg_in ? (~data + 1'b1) : data;
    mag_ext  = MAG_W'(mag);
    avail_in = sign ? int'(NUM_DIGITS) - 1 : int'(NUM_DIGITS);
    hex_ovf  = |(mag_ext >> (4 * avail_in));
  end

  // One double-dabble step: add-3 correction, then shift the next magnitude bit in.
  always_comb begin
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? 4'(bcd_q[4*i +: 4] + 4'd3)
                                                    : bcd_q[4*i +: 4];
    end
    carry    = bcd_adj[BCD_W-1];
    bcd_step = {bcd_adj[BCD_W-2:0], sh_q[DATA_W-1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sh_d    = sh_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    swap    = 1'b0;
    src_nib = mag_ext[BCD_W-1:0];
    src_ovf = hex_ovf;
    src_neg = neg_in;
    src_sgn = sign;
    case (state_q)
      StIdle: begin
        if (load) begin
          if (hex_dec) begin
            swap = 1'b1;
          end else begin
            state_d = StConv;
            cnt_d   = '0;
            bcd_d   = '0;
            sh_d    = mag;
            ovf_d   = 1'b0;
            neg_d   = neg_in;
            sgn_d   = sign;
          end
        end
      end
      StConv: begin
        bcd_d   = bcd_step;
        sh_d    = sh_q << 1;
        ovf_d   = ovf_q | carry;
        cnt_d   = cnt_q + 1'b1;
        src_nib = bcd_step;
        src_ovf = ovf_q | carry | (sgn_q & (|bcd_step[BCD_W-1 -: 4]));
        src_neg = neg_q;
        src_sgn = sgn_q;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = StIdle;
          swap    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-digit content built from the source nibbles at swap time.
  always_comb begin
    int avail;
`ifdef SSEG_LZB_EN
    int msd;
`endif
    avail = src_sgn ? int'(NUM_DIGITS) - 1 : int'(NUM_DIGITS);
`ifdef SSEG_LZB_EN
    msd = 0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (i < avail && src_nib[4*i +: 4] != 4'h0) msd = i;
    end
`endif
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      new_seg[i]   = font(src_nib[4*i +: 4]);
      new_blank[i] = 1'b0;
      if (src_ovf) begin
        new_seg[i] = SegDash;
`ifdef SSEG_LZB_EN
      end else if (i > msd) begin
        if (src_neg && i == msd + 1) begin
          new_seg[i] = SegDash;
        end else begin
          new_seg[i]   = SegBlank;
          new_blank[i] = 1'b1;
        end
`else
      end else if (i >= avail) begin
        if (src_neg) begin
          new_seg[i] = SegDash;
        end else begin
          new_seg[i]   = SegBlank;
          new_blank[i] = 1'b1;
        end
`endif
      end
    end
    disp_seg_d   = swap ? new_seg : disp_seg_q;
    disp_blank_d = swap ? new_blank : disp_blank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      div_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      bcd_q        <= '0;
      sh_q         <= '0;
      ovf_q        <= 1'b0;
      neg_q        <= 1'b0;
      sgn_q        <= 1'b0;
      disp_seg_q   <= {NUM_DIGITS{SegZero}};
      disp_blank_q <= '0;
      an_q         <= '1;
      seg_q        <= SegBlank;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      bcd_q        <= bcd_d;
      sh_q         <= sh_d;
      ovf_q        <= ovf_d;
      neg_q        <= neg_d;
      sgn_q        <= sgn_d;
      disp_seg_q   <= disp_seg_d;
      disp_blank_q <= disp_blank_d;
      // Outputs use next-state index and content so a swap lands on a whole digit.
      an_q         <= ~(NUM_DIGITS'(1) << idx_d);
      seg_q        <= disp_seg_d[idx_d];
      dp_q         <= disp_blank_d[idx_d] | ~dp_sel[idx_d];
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = (state_q == StConv);

endmodule

// File: tb/tb_sseg_scan_n.sv
// Directed self-checking bench for sseg_scan_n (4 digits, 16-bit data, refresh divide of 4).
module tb_sseg_scan_n;
  localparam int ND = 4;
  localparam int DW = 16;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data = '0;
  logic          load = 1'b0;
  logic          hex_dec = 1'b0;
  logic          sign = 1'b0;
  logic [ND-1:0] dp_sel = '0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic          busy;

  int total = 0;
  int bad = 0;
  logic [6:0] cap [ND-1:0];
  logic [6:0] expv [ND-1:0];
  logic       busy_seen;

  always #5 clk = ~clk;

  sseg_scan_n #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .hex_dec(hex_dec), .sign(sign),
    .dp_sel(dp_sel), .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  function automatic int an_idx(input logic [ND-1:0] a);
    for (int i = 0; i < ND; i++) if (a == ~(ND'(1) << i)) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record the segments shown in each digit slot over two full scan rotations.
  task automatic capture();
    int k;
    busy_seen = 1'b0;
    for (int i = 0; i < ND; i++) cap[i] = 7'hxx;
    repeat (2 * ND * RD) begin
      tick();
      k = an_idx(an);
      if (busy) busy_seen = 1'b1;
      if (k >= 0) cap[k] = seg;
    end
  endtask

  task automatic do_load(input logic [DW-1:0] d, input logic hx, input logic sg);
    data = d;
    hex_dec = hx;
    sign = sg;
    load = 1'b1;
    tick();
    load = 1'b0;
    sign = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (busy && n < 40) begin
      tick();
      if (busy) n++;
    end
  endtask

  task automatic test_reset();
    logic [ND-1:0] exp_an [5];
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0;
    #12;
    total++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: an=%b seg=%h dp=%b busy=%b, want 1111 7f 1 0", an, seg, dp,
               busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      repeat ((s == 0) ? 1 : RD) tick();
      total++;
      if (an !== exp_an[s]) begin
        bad++;
        $display("FAIL scan_step%0d: an=%b want %b", s, an, exp_an[s]);
      end
    end
    capture();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (cap[i] !== 7'h40) begin
        bad++;
        $display("FAIL reset_digit%0d: seg=%h want 40", i, cap[i]);
      end
    end
    total++;
    if (busy_seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: busy_seen=%b want 0", busy_seen);
    end
  endtask

  task automatic test_hex();
    int k;
    expv = '{7'h79, 7'h08, 7'h30, 7'h0E};
    do_load(16'h1A3F, 1'b1, 1'b0);
    k = an_idx(an);
    total++;
    if (k < 0 || seg !== expv[k]) begin
      bad++;
      $display("FAIL hex_next_cycle: an=%b seg=%h", an, seg);
    end
    capture();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (cap[i] !== expv[i]) begin
        bad++;
        $display("FAIL hex_digit%0d: seg=%h want %h", i, cap[i], expv[i]);
      end
    end
    total++;
    if (busy_seen !== 1'b0) begin
      bad++;
      $display("FAIL hex_busy: busy_seen=%b want 0", busy_seen);
    end
  endtask

  task automatic test_dec_1234();
    int n;
    int held_err;
    int k;
    logic [6:0] old [ND-1:0];
    old = '{7'h79, 7'h08, 7'h30, 7'h0E};
    expv = '{7'h79, 7'h24, 7'h30, 7'h19};
    held_err = 0;
    do_load(16'd1234, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      k = an_idx(an);
      if (k < 0 || seg !== old[k]) held_err++;
      // Second load on the 8th busy cycle must be ignored.
      if (n == 8) begin
        data = 16'h9999;
        hex_dec = 1'b1;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL dec_busy_len: cycles=%0d want 16", n);
    end
    total++;
    if (held_err !== 0) begin
      bad++;
      $display("FAIL dec_old_held: bad_cycles=%0d want 0", held_err);
    end
    capture();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (cap[i] !== expv[i]) begin
        bad++;
        $display("FAIL dec_digit%0d: seg=%h want %h", i, cap[i], expv[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    do_load(16'd12345, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      // Load during the final busy cycle must be ignored.
      if (n == 16) begin
        data = 16'd1;
        hex_dec = 1'b0;
        load = 1'b1;
      end
      tick();
    end
    load = 1'b0;
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL ovf_busy_len: cycles=%0d want 16", n);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL final_cycle_load: busy=%b want 0", busy);
    end
    capture();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (cap[i] !== 7'h3F) begin
        bad++;
        $display("FAIL dec_ovf_digit%0d: seg=%h want 3f", i, cap[i]);
      end
    end
  endtask

  task automatic test_signed();
    int n;
    expv = '{7'h3F, 7'h79, 7'h24, 7'h30};
    do_load(16'hFF85, 1'b0, 1'b1);
    wait_done(n);
    capture();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (cap[i] !== expv[i]) begin
        bad++;
        $display("FAIL neg123_digit%0d: seg=%h want %h", i, cap[i], expv[i]);
      end
    end
    do_load(16'h1234, 1'b1, 1'b1);
    capture();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (cap[i] !== 7'h3F) begin
        bad++;
        $display("FAIL signed_hex_ovf_digit%0d: seg=%h want 3f", i, cap[i]);
      end
    end
`ifdef SSEG_LZB_EN
    expv = '{7'h7F, 7'h7F, 7'h3F, 7'h78};
`else
    expv = '{7'h3F, 7'h40, 7'h40, 7'h78};
`endif
    do_load(16'hFFF9, 1'b0, 1'b1);
    wait_done(n);
    capture();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (cap[i] !== expv[i]) begin
        bad++;
        $display("FAIL neg7_digit%0d: seg=%h want %h", i, cap[i], expv[i]);
      end
    end
  endtask

  task automatic test_midreset_dp();
    int n;
    logic exp_dp;
    do_load(16'd4321, 1'b0, 1'b0);
    n = 1;
    while (busy && n < 5) begin
      tick();
      n++;
    end
    #2 rst_n = 1'b0;
    #2;
    total++;
    if (busy !== 1'b0 || an !== 4'b1111) begin
      bad++;
      $display("FAIL midreset: busy=%b an=%b want 0 1111", busy, an);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    dp_sel = 4'b0100;
    capture();
    for (int i = 0; i < ND; i++) begin
      total++;
      if (cap[i] !== 7'h40) begin
        bad++;
        $display("FAIL midreset_digit%0d: seg=%h want 40", i, cap[i]);
      end
    end
    total++;
    if (busy_seen !== 1'b0) begin
      bad++;
      $display("FAIL midreset_busy: busy_seen=%b want 0", busy_seen);
    end
    repeat (2 * ND * RD) begin
      tick();
      exp_dp = (an == 4'b1011) ? 1'b0 : 1'b1;
      total++;
      if (dp !== exp_dp) begin
        bad++;
        $display("FAIL dp: an=%b dp=%b want %b", an, dp, exp_dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_dec_1234();
    test_overflow();
    test_signed();
    test_midreset_dp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_n.md
Name: sseg_scan_n

Overview:
- Parametrised N-digit seven-segment display controller. Latches a value on a load strobe and, in decimal mode, converts binary to BCD sequentially (double-dabble).
- Time-multiplexes the digits onto one shared segment bus.
- Successor to the fixed 4-digit combinational driver: adds arbitrary digit count and data width, a real refresh scanner, overflow indication, and sign handling in both modes.
- Sits between board switches or core logic and the display pins.

Parameters:
- NUM_DIGITS, 4: number of digits (2..8).
- DATA_W, 16: input value width (4..32).
- REFRESH_DIV, 100000: clk cycles each digit stays lit (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data  in  DATA_W  value to display.
- load  in  1  1-cycle strobe; captures data, hex_dec, sign.
- hex_dec  in  1  1 = hex, 0 = decimal.
- sign  in  1  1 = data is two's complement.
- dp_sel  in  NUM_DIGITS  decimal point per digit, bit 0 = rightmost; live, not latched.
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- busy  out  1  conversion in progress.

Behaviour:
- Reset (async, rst_n=0):
  - an = all 1, seg = 7'h7F, dp = 1, busy = 0.
  - Scan index = 0, divider = 0.
  - Display register holds all digits '0', no overflow.
- Scanner:
  - Divider counts 0..REFRESH_DIV-1. On the terminal count the index advances 0→1→…→NUM_DIGITS-1→0.
  - an[idx] = 0, all other bits = 1. seg/dp are registered together with an, so there is no glitch between digits.
  - First digit lights the cycle after reset deasserts.
- Load acceptance:
  - load is accepted only when busy = 0. load while busy = 1, including the final busy cycle, is ignored.
  - Magnitude: if sign = 1 and data[MSB] = 1, mag = -data as unsigned DATA_W; otherwise mag = data. neg = sign & data[MSB].
  - Available digits: avail = NUM_DIGITS - sign.
- Hex mode:
  - The display register updates the cycle after load. busy does not assert.
  - Overflow if mag needs more than avail nibbles.
- Decimal mode:
  - busy rises the cycle after load and stays high exactly DATA_W cycles. Each cycle: add-3 to every BCD nibble >= 5, then shift one mag bit in.
  - BCD register is NUM_DIGITS*4 bits. Any 1 shifted out of the top sets a sticky overflow flag. If sign = 1, a nonzero top BCD nibble at completion also sets overflow.
  - The display register swaps atomically in the cycle busy falls. The previous value stays displayed until then.
- Digit content:
  - Overflow: every digit shows '-' (seg = 7'b0111111).
  - neg without overflow: leftmost digit shows '-'.
  - Sign position when sign = 1 and value non-negative: leftmost digit shows blank (7'h7F).
  - Remaining digits show nibbles, most significant at left.
- Font: standard hex font.
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- dp = ~dp_sel[idx]. dp_sel is ignored for blanked digits.
- Reset mid-conversion: aborts, busy = 0, display returns to all '0'.
- Simultaneous divider wrap and display swap: the new content applies from the newly selected digit onward. No digit shows mixed old/new segments within one slot.

Optional Feature:
- Macro SSEG_LZB_EN.
- Defined: leading-zero blanking. Leading zero digits show blank, and the rightmost digit is never blanked (0 shows "   0"). With neg, '-' moves to the digit immediately left of the most significant shown digit; all digits further left are blank. Overflow dashes are unaffected.
- Undefined: leading zeros are displayed, and '-' sits in the leftmost digit.

Test Plan (NUM_DIGITS=4, DATA_W=16, REFRESH_DIV=4):
- Reset release:
  - an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles.
  - seg = 40 on each digit; busy = 0.
- load, hex_dec=1, data=16'h1A3F:
  - Next cycle the digits (left to right) are 1, A, 3, F; digit A gives seg = 08.
  - busy never rises.
- load, dec, data=16'd1234:
  - busy high exactly 16 cycles; old display held until busy falls; then digits 1, 2, 3, 4.
  - A second load issued on the 8th busy cycle is ignored.
- load, dec, data=16'd12345:
  - All digits '-' (seg = 3F) after conversion.
  - Signed hex load of 16'h1234 also gives all '-'.
- load, dec, sign=1, data=16'hFF85 (-123):
  - Without macro: digits are -, 1, 2, 3.
  - With SSEG_LZB_EN, data=16'hFFF9 (-7): digits are blank, blank, -, 7.
- Mid-conversion reset and dp:
  - rst_n pulse at busy cycle 5 → busy = 0, display shows 0000.
  - dp_sel=4'b0100 → dp = 0 only while an = 1011.
